// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the RV32I data-memory port: funct3 codes, responder states,
// request legality, store lane steering and load extension.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_t;

    // Illegal size code or an access not aligned to its natural size.
    function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic bad_f3;
        logic misaligned;
        if (we) bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
        else    bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return bad_f3 || misaligned;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Right-aligned store data copied into every lane so the byte enables pick the target.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_BU:   return {24'h0, sh[7:0]};
            F3_H:    return {{16{sh[15]}}, sh[15:0]};
            F3_HU:   return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Word-organised RAM built from four independent byte lanes, per-lane write enable, registered read.
// Contents are never reset; read data holds until the next read enable.
module dmem_lane_ram #(
    parameter int WORDS = 128,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] rdata_q;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] lane_q [WORDS];

        always_ff @(posedge clk) begin
            if (be_i[l]) lane_q[addr_i] <= wdata_i[8*l +: 8];
            if (re_i)    rdata_q[8*l +: 8] <= lane_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core load/store port: one request at a time, WAIT_CYCLES wait
// states, then a one-cycle ACCESS and a one-cycle response strobe.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int         WORDS     = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] hold_rdata_q;
    logic              hold_err_q;

    logic              handshake;
    logic [3:0]        ram_be;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rdata_now;

    assign req_ready = (state_q == IDLE) && reset;
    assign handshake = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ram_be  = 4'b0000;
        ram_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ACCESS: begin
                state_d = RESP;
                // A reset landing on the ACCESS edge still suppresses the write.
                if (!err_q && reset) begin
                    if (we_q) ram_be = store_be(f3_q, addr_q[1:0]);
                    else      ram_re = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            f3_q    <= 3'b000;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (handshake) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                f3_q    <= req_funct3;
                wdata_q <= req_wdata;
                err_q   <= req_error(req_we, req_funct3, req_addr[1:0]);
            end
        end
    end

    dmem_lane_ram #(.WORDS(WORDS)) u_ram (
        .clk     (clk),
        .addr_i  (addr_q[ADDR_W-1:2]),
        .be_i    (ram_be),
        .wdata_i (store_lanes(f3_q, wdata_q)),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    assign rdata_now = (err_q || we_q) ? '0 : load_extend(ram_rdata, f3_q, addr_q[1:0]);

    // The RAM output is live only during RESP; afterwards the hold registers keep the response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_rdata_q <= '0;
            hold_err_q   <= 1'b0;
        end else if (state_q == RESP) begin
            hold_rdata_q <= rdata_now;
            hold_err_q   <= err_q;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_valid ? rdata_now : hold_rdata_q;
    assign resp_err   = resp_valid ? err_q : hold_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked against a byte-array model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    int          sel;

    logic        rdy0, rdy1, rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl [2][512];

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 0), .req_ready(rdy0),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0));

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 1), .req_ready(rdy1),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1));

    wire        cur_rdy = (sel == 1) ? rdy1 : rdy0;
    wire        cur_rv  = (sel == 1) ? rv1  : rv0;
    wire [31:0] cur_rd  = (sel == 1) ? rd1  : rd0;
    wire        cur_er  = (sel == 1) ? er1  : er0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d got=0x%08h exp=0x%08h", name, sel, got, exp);
        end
    endtask

    // Reference: little-endian byte array, natural-size alignment rule, arithmetic sign extension.
    task automatic model_op(input logic we, input logic [8:0] addr, input logic [2:0] f3,
                            input logic [31:0] wdata, output logic [31:0] rd, output logic err);
        int size;
        logic legal;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err   = !legal || ((int'(addr) % size) != 0);
        rd    = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mdl[sel][int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) rd = rd | (32'(mdl[sel][int'(addr) + i]) << (8*i));
                if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [8:0] addr, input logic [2:0] f3,
                          input logic [31:0] wdata, output logic [31:0] got_rd, output logic got_er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          waits, lat;
        logic        seen_rdy;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wdata;
        waits = 0;
        seen_rdy = cur_rdy;
        while (!seen_rdy && waits < 40) begin
            @(negedge clk);
            waits++;
            seen_rdy = cur_rdy;
        end
        chk("accept_wait", waits, 0);
        @(posedge clk);
        model_op(we, addr, f3, wdata, exp_rd, exp_er);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = 9'($urandom); req_funct3 = 3'($urandom);
        req_wdata = $urandom;
        lat = 1;
        while (!cur_rv && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, (sel == 1) ? 2 : 4);
        got_rd = cur_rd;
        got_er = cur_er;
        chk("rdata_vs_model", got_rd, exp_rd);
        chk("err_vs_model", 32'(got_er), 32'(exp_er));
        @(negedge clk);
        chk("strobe_one_cycle", 32'(cur_rv), 0);
        chk("rdata_hold", cur_rd, got_rd);
    endtask

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        logic        er;
        sel = 0;
        reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h0;
        req_funct3 = 3'b010; req_wdata = 32'h0;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset_ready0", 32'(rdy0), 0);
            chk("reset_ready1", 32'(rdy1), 0);
            chk("reset_valid", 32'(rv0 | rv1), 0);
            chk("reset_rdata", rd0 | rd1, 0);
            chk("reset_err", 32'(er0 | er1), 0);
        end
        req_valid = 1'b0;
        reset = 1'b1;

        // Give every word a known value in both RAMs.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int w = 0; w < 128; w++) do_req(1'b1, 9'(w * 4), 3'b010, $urandom, rd, er);
        end

        vecs.push_back('{1'b1, 9'h010, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 9'h010, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 9'h013, 3'b000, 32'h0,        32'hFFFFFFDE, 1'b0});
        vecs.push_back('{1'b0, 9'h013, 3'b100, 32'h0,        32'h000000DE, 1'b0});
        vecs.push_back('{1'b0, 9'h010, 3'b001, 32'h0,        32'hFFFFBEEF, 1'b0});
        vecs.push_back('{1'b0, 9'h012, 3'b101, 32'h0,        32'h0000DEAD, 1'b0});
        vecs.push_back('{1'b1, 9'h011, 3'b000, 32'h000000AA, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 9'h010, 3'b010, 32'h0,        32'hDEADAAEF, 1'b0});
        vecs.push_back('{1'b0, 9'h012, 3'b010, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 9'h011, 3'b001, 32'h00005555, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 9'h010, 3'b011, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 9'h010, 3'b100, 32'h11111111, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 9'h012, 3'b010, 32'h22222222, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 9'h010, 3'b010, 32'h0,        32'hDEADAAEF, 1'b0});

        for (int s = 0; s < 2; s++) begin
            sel = s;
            foreach (vecs[i]) begin
                do_req(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wdata, rd, er);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
                chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_er));
            end
        end

        // Reset during the wait states of a store: the write and its response must vanish.
        sel = 0;
        do_req(1'b1, 9'h020, 3'b010, 32'hCAFEF00D, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020; req_funct3 = 3'b010;
        req_wdata = 32'h12345678;
        chk("abort_ready", 32'(rdy0), 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort_no_valid_in_reset", 32'(rv0), 0);
        end
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_no_valid_after", 32'(rv0), 0);
        end
        do_req(1'b0, 9'h020, 3'b010, 32'h0, rd, er);
        chk("abort_store_dropped", rd, 32'hCAFEF00D);

        // Random traffic, biased towards aligned addresses and legal sizes.
        for (int n = 0; n < 300; n++) begin
            logic [8:0] a;
            logic [2:0] f;
            sel = int'($urandom_range(1, 0));
            f   = ($urandom_range(3, 0) == 0) ? 3'($urandom) : 3'($urandom_range(2, 0) | ($urandom_range(1, 0) << 2));
            a   = 9'($urandom);
            if ($urandom_range(1, 0) == 1) a[1:0] = (f[1:0] == 2'b00) ? a[1:0] : (f[1:0] == 2'b01) ? {a[1], 1'b0} : 2'b00;
            do_req(1'($urandom), a, f, $urandom, rd, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
